// File: rtl/servo_pwm_capture_pkg.sv
// Shared register map and constants for the servo PWM capture block.
// The servo generator reuses the same offsets.
package servo_pwm_capture_pkg;

   localparam int unsigned DEFAULT_TIMEOUT = 4000000;

   localparam logic [7:0] X_WIDTH_OFS  = 8'h00;
   localparam logic [7:0] Y_WIDTH_OFS  = 8'h04;
   localparam logic [7:0] X_PERIOD_OFS = 8'h08;
   localparam logic [7:0] Y_PERIOD_OFS = 8'h0C;
   localparam logic [7:0] STATUS_OFS   = 8'h10;
   localparam logic [7:0] CTRL_OFS     = 8'h14;

   localparam int unsigned ST_X_VALID = 0;
   localparam int unsigned ST_Y_VALID = 1;
   localparam int unsigned ST_X_NEW   = 2;
   localparam int unsigned ST_Y_NEW   = 3;
   localparam int unsigned ST_X_LOST  = 4;
   localparam int unsigned ST_Y_LOST  = 5;

   localparam int unsigned CTRL_ENABLE = 0;

   typedef enum logic [2:0] {
      REG_X_WIDTH  = X_WIDTH_OFS[4:2],
      REG_Y_WIDTH  = Y_WIDTH_OFS[4:2],
      REG_X_PERIOD = X_PERIOD_OFS[4:2],
      REG_Y_PERIOD = Y_PERIOD_OFS[4:2],
      REG_STATUS   = STATUS_OFS[4:2],
      REG_CTRL     = CTRL_OFS[4:2]
   } reg_sel_e;

endpackage

// File: rtl/servo_pwm_capture_channel.sv
// One PWM capture channel: synchronizer, edge detect, high-time and period
// counters with saturation at TIMEOUT, captured WIDTH/PERIOD and VALID.
module pwm_capture_channel
   import servo_pwm_capture_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] width,
   output logic [CNT_W-1:0] period,
   output logic             valid,
   output logic             capture_evt,
   output logic             lost_evt
);

   localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] TMO_M1 = CNT_W'(TIMEOUT - 1);

   logic             s1_q, s1_d, s2_q, s2_d, dly_q, dly_d;
   logic [2:0]       prime_q, prime_d;
   logic [CNT_W-1:0] hc_q, hc_d, pc_q, pc_d;
   logic [CNT_W-1:0] width_q, width_d, period_q, period_d;
   logic             armed_q, armed_d, valid_q, valid_d;
   logic             rise, fall;

   always_comb begin
      s1_d     = pwm_in;
      s2_d     = s1_q;
      dly_d    = s2_q;
      prime_d  = {prime_q[1:0], 1'b1};
      hc_d     = hc_q;
      pc_d     = pc_q;
      width_d  = width_q;
      period_d = period_q;
      armed_d  = armed_q;
      valid_d  = valid_q;
      capture_evt = 1'b0;
      lost_evt    = 1'b0;

      // Edges are ignored until the sync/delay pipeline holds real samples,
      // so a pin already high when reset releases is not taken as a rise.
      rise = prime_q[2] & s2_q & ~dly_q;
      fall = prime_q[2] & ~s2_q & dly_q;

      if (!enable) begin
         hc_d    = '0;
         pc_d    = '0;
         armed_d = 1'b0;
         valid_d = 1'b0;
      end else begin
         // hc == 0 marks a pulse whose rise was not seen; it is never captured.
         if (rise) begin
            hc_d = CNT_W'(1);
         end else if (fall) begin
            if (hc_q != '0) width_d = hc_q;
            hc_d = '0;
         end else if (s2_q && (hc_q != '0) && (hc_q != TMO)) begin
            hc_d = hc_q + CNT_W'(1);
         end

         if (rise) begin
            if (armed_q) begin
               period_d    = pc_q;
               valid_d     = 1'b1;
               capture_evt = 1'b1;
            end
            pc_d    = CNT_W'(1);
            armed_d = 1'b1;
         end else if (pc_q != TMO) begin
            pc_d = pc_q + CNT_W'(1);
            if (pc_q == TMO_M1) begin
               armed_d  = 1'b0;
               valid_d  = 1'b0;
               lost_evt = 1'b1;
            end
         end
      end

      width  = width_q;
      period = period_q;
      valid  = valid_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         dly_q    <= 1'b0;
         prime_q  <= '0;
         hc_q     <= '0;
         pc_q     <= '0;
         width_q  <= '0;
         period_q <= '0;
         armed_q  <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         dly_q    <= dly_d;
         prime_q  <= prime_d;
         hc_q     <= hc_d;
         pc_q     <= pc_d;
         width_q  <= width_d;
         period_q <= period_d;
         armed_q  <= armed_d;
         valid_q  <= valid_d;
      end
   end

endmodule

// File: rtl/servo_pwm_capture.sv
// APB3 slave measuring high-time and period of two servo PWM inputs.
// Holds the APB decode, STATUS/CTRL registers and the read mux.
module servo_pwm_capture
   import servo_pwm_capture_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
   parameter int unsigned CNT_W   = 32
) (
   input  logic        PCLK,
   input  logic        PRESERN,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [31:0] PADDR,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   input  logic        x_pwm_in,
   input  logic        y_pwm_in
);

   logic [CNT_W-1:0] x_width, x_period, y_width, y_period;
   logic             x_valid, y_valid, x_cap, y_cap, x_lost, y_lost;
   logic             enable_q, enable_d;
   logic [1:0]       new_q, new_d, lost_q, lost_d;
   logic             wr_en, sts_wr, ctrl_wr;
   logic [31:0]      status;
   reg_sel_e         sel;
   logic             unused_apb;

   pwm_capture_channel #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_x (
      .clk(PCLK), .rst_n(PRESERN), .enable(enable_q), .pwm_in(x_pwm_in),
      .width(x_width), .period(x_period), .valid(x_valid),
      .capture_evt(x_cap), .lost_evt(x_lost)
   );

   pwm_capture_channel #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_y (
      .clk(PCLK), .rst_n(PRESERN), .enable(enable_q), .pwm_in(y_pwm_in),
      .width(y_width), .period(y_period), .valid(y_valid),
      .capture_evt(y_cap), .lost_evt(y_lost)
   );

   always_comb begin
      sel     = reg_sel_e'(PADDR[4:2]);
      wr_en   = PSEL & PENABLE & PWRITE;
      sts_wr  = wr_en && (sel == REG_STATUS);
      ctrl_wr = wr_en && (sel == REG_CTRL);

      enable_d = ctrl_wr ? PWDATA[CTRL_ENABLE] : enable_q;

      // Hardware set wins over a same-cycle write-one-to-clear.
      new_d[0]  = (new_q[0]  & ~(sts_wr & PWDATA[ST_X_NEW]))  | x_cap;
      new_d[1]  = (new_q[1]  & ~(sts_wr & PWDATA[ST_Y_NEW]))  | y_cap;
      lost_d[0] = (lost_q[0] & ~(sts_wr & PWDATA[ST_X_LOST])) | x_lost;
      lost_d[1] = (lost_q[1] & ~(sts_wr & PWDATA[ST_Y_LOST])) | y_lost;

      status             = '0;
      status[ST_X_VALID] = x_valid;
      status[ST_Y_VALID] = y_valid;
      status[ST_X_NEW]   = new_q[0];
      status[ST_Y_NEW]   = new_q[1];
      status[ST_X_LOST]  = lost_q[0];
      status[ST_Y_LOST]  = lost_q[1];

      PRDATA = '0;
      if (PSEL && !PWRITE) begin
         case (sel)
            REG_X_WIDTH:  PRDATA = 32'(x_width);
            REG_Y_WIDTH:  PRDATA = 32'(y_width);
            REG_X_PERIOD: PRDATA = 32'(x_period);
            REG_Y_PERIOD: PRDATA = 32'(y_period);
            REG_STATUS:   PRDATA = status;
            REG_CTRL:     PRDATA = {31'd0, enable_q};
            default:      PRDATA = '0;
         endcase
      end

      PREADY     = 1'b1;
      PSLVERR    = 1'b0;
      unused_apb = ^{PADDR[31:5], PADDR[1:0], PWDATA[31:6], PWDATA[1]};
   end

   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         enable_q <= 1'b1;
         new_q    <= '0;
         lost_q   <= '0;
      end else begin
         enable_q <= enable_d;
         new_q    <= new_d;
         lost_q   <= lost_d;
      end
   end

endmodule
